// File: rtl/ss_stream_integrator_pkg.sv
// Shared definitions for the stochastic-stream blocks: FSM encodings and default sizing.
package ss_stream_integrator_pkg;

  typedef enum logic {
    SS_IDLE = 1'b0,
    SS_RUN  = 1'b1
  } ss_state_e;

  localparam int SS_DEFAULT_N        = 16;
  localparam int SS_DEFAULT_WIN_LOG2 = 8;

endpackage

// File: rtl/ss_sat_counter.sv
// Saturating up-counter with synchronous clear; 'total' is the value including this
// cycle's increment, so a caller can capture the final sum on the clearing edge.
module ss_sat_counter #(
  parameter int N = 16
) (
  input  logic         CLK,
  input  logic         INIT_N,
  input  logic         clr,
  input  logic         inc,
  output logic [N-1:0] total
);

  logic [N-1:0] value;

  // Holds at all-ones instead of wrapping.
  assign total = (inc && !(&value)) ? value + N'(1) : value;

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else begin
      value <= total;
    end
  end

endmodule

// File: rtl/ss_stream_integrator.sv
// Integrates a 1-bit stochastic stream over 2**WIN_LOG2-cycle windows and publishes the
// saturated ones-count through a VALID/READY output register with a sticky overrun flag.
module ss_stream_integrator
  import ss_stream_integrator_pkg::*;
#(
  parameter int N        = SS_DEFAULT_N,
  parameter int WIN_LOG2 = SS_DEFAULT_WIN_LOG2
) (
  input  logic         CLK,
  input  logic         INIT_N,
  input  logic         EN,
  input  logic         CLR,
  input  logic         IN,
  input  logic         READY,
  output logic [N-1:0] COUNT,
  output logic         VALID,
  output logic         OVERRUN,
  output logic         ACTIVE,
  output ss_state_e    STATE
);

  ss_state_e           state, state_next;
  logic [WIN_LOG2-1:0] win;
  logic                run;
  logic                win_end;
  logic                acc_clr;
  logic [N-1:0]        acc_total;

  assign run     = (state == SS_RUN);
  assign win_end = run && (&win);
  // Partial windows are dropped as soon as EN falls; a completed window still publishes.
  assign acc_clr = CLR || !run || !EN || win_end;

  ss_sat_counter #(.N(N)) u_acc (
    .CLK    (CLK),
    .INIT_N (INIT_N),
    .clr    (acc_clr),
    .inc    (run && IN),
    .total  (acc_total)
  );

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      state <= SS_IDLE;
    end else if (CLR) begin
      state <= SS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SS_IDLE: if (EN)  state_next = SS_RUN;
      SS_RUN:  if (!EN) state_next = SS_IDLE;
      default: state_next = SS_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      win <= '0;
    end else if (CLR || !run || !EN) begin
      win <= '0;
    end else begin
      win <= win + WIN_LOG2'(1);
    end
  end

  // Handshake: a result is consumed on any edge where VALID=1 and READY=1. A result
  // loading on the same edge takes priority: VALID stays 1 and only an unconsumed
  // result being replaced (READY=0) raises OVERRUN. COUNT holds until the next load.
  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      COUNT   <= '0;
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
    end else if (CLR) begin
      COUNT   <= '0;
      VALID   <= 1'b0;
      OVERRUN <= 1'b0;
    end else if (win_end) begin
      COUNT <= acc_total;
      VALID <= 1'b1;
      if (VALID && !READY) OVERRUN <= 1'b1;
    end else if (VALID && READY) begin
      VALID <= 1'b0;
    end
  end

  assign ACTIVE = run;
  assign STATE  = state;

endmodule
